// File: rtl/counter_cmd_seq.sv
// ---------------------------------------------------------------------------
// counter_cmd_seq
//
// Sequences commands for a downstream 4-bit up/down counter with a
// synchronous load input. Commands are queued in a 4-entry FIFO and executed
// one after another with no idle cycles between them.
//
// Ports
//   clk        : single clock, all state updates on posedge
//   rst        : asynchronous active-low reset, clears all state at once
//   cmd_valid  : a command is offered this cycle
//   cmd_op     : 00 UP, 01 DOWN, 10 LOAD, 11 reserved
//   cmd_data   : load value, used by LOAD only
//   cmd_len    : UP/DOWN run length, N gives N+1 count cycles
//   cmd_ready  : command taken at posedge when cmd_valid && cmd_ready
//   load       : counter load enable (registered)
//   updown     : counter direction, 1 = up (registered)
//   data       : counter load data (registered)
//   busy       : executing a command or FIFO non-empty (registered)
//   fifo_cnt   : FIFO occupancy 0..4 (registered)
//   cmd_err    : one-cycle pulse after a reserved op is accepted
//
// While idle the block drives load=1 with data equal to the shadow copy of
// the counter, so the counter reloads its own value and stays frozen.
// ---------------------------------------------------------------------------

// Structural invariants of the sequencer, checked in simulation only.
module counter_cmd_seq_chk (
  input logic       clk,
  input logic       rst,
  input logic       cmd_ready,
  input logic [2:0] fifo_cnt,
  input logic       busy,
  input logic       run
);

  a_cnt_range: assert property (@(posedge clk) disable iff (!rst)
    fifo_cnt <= 3'd4);

  a_no_ready_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(cmd_ready && (fifo_cnt == 3'd4)));

  a_busy_def: assert property (@(posedge clk) disable iff (!rst)
    busy == (run || (fifo_cnt != 3'd0)));

endmodule

module counter_cmd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_data,
  input  logic [3:0] cmd_len,
  output logic       cmd_ready,
  output logic       load,
  output logic       updown,
  output logic [3:0] data,
  output logic       busy,
  output logic [2:0] fifo_cnt,
  output logic       cmd_err
);

  localparam logic [1:0] OP_UP   = 2'b00;
  localparam logic [1:0] OP_DOWN = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // One counting step exactly as the downstream counter applies it.
  function automatic logic [3:0] count_step(input logic [1:0] op,
                                            input logic [3:0] val);
    logic [3:0] res;
    case (op)
      OP_UP:   res = val + 4'd1;
      OP_DOWN: res = val - 4'd1;
      default: res = val;
    endcase
    return res;
  endfunction

  // FIFO storage: {op[1:0], data[3:0], len[3:0]}
  logic [9:0] fifo_mem_q [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] cnt_q, cnt_d;

  logic       ready_q;
  logic       busy_q;
  logic       err_q, err_d;

  logic [0:0] state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [3:0] remain_q, remain_d;   // cycles left after the current one
  logic [3:0] shadow_q, shadow_d;   // counter value once current outputs apply

  logic       load_q, load_d;
  logic       updown_q, updown_d;
  logic [3:0] data_q, data_d;

  logic       accept_s;
  logic       push_s;
  logic       pop_s;
  logic       can_pop_s;
  logic [9:0] head_s;
  logic [1:0] head_op_s;
  logic [3:0] head_data_s;
  logic [3:0] head_len_s;

  assign accept_s    = cmd_valid && ready_q;
  // Reserved ops complete the handshake but are never stored.
  assign push_s      = accept_s && (cmd_op != OP_RSVD);
  // A new command may start when idle or in the last cycle of the current
  // one; this is what gives zero-gap back-to-back execution.
  assign can_pop_s   = (state_q == ST_IDLE) || (remain_q == 4'd0);
  assign pop_s       = (cnt_q != 3'd0) && can_pop_s;

  assign head_s      = fifo_mem_q[rd_ptr_q];
  assign head_op_s   = head_s[9:8];
  assign head_data_s = head_s[7:4];
  assign head_len_s  = head_s[3:0];

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Sequencer next-state: pick up a new command, continue a run, or hold.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    remain_d = remain_q;
    shadow_d = shadow_q;
    load_d   = 1'b1;
    updown_d = 1'b0;
    data_d   = shadow_q;
    if (pop_s) begin
      state_d = ST_RUN;
      op_d    = head_op_s;
      case (head_op_s)
        OP_LOAD: begin
          remain_d = 4'd0;
          load_d   = 1'b1;
          updown_d = 1'b0;
          data_d   = head_data_s;
          shadow_d = head_data_s;
        end
        OP_UP, OP_DOWN: begin
          remain_d = head_len_s;
          load_d   = 1'b0;
          updown_d = (head_op_s == OP_UP);
          data_d   = shadow_q;
          shadow_d = count_step(head_op_s, shadow_q);
        end
        default: begin
          state_d  = ST_IDLE;
          remain_d = 4'd0;
          load_d   = 1'b1;
          updown_d = 1'b0;
          data_d   = shadow_q;
          shadow_d = shadow_q;
        end
      endcase
    end else if ((state_q == ST_RUN) && (remain_q != 4'd0)) begin
      // Only UP/DOWN runs last more than one cycle.
      remain_d = remain_q - 4'd1;
      case (op_q)
        OP_UP, OP_DOWN: begin
          load_d   = 1'b0;
          updown_d = (op_q == OP_UP);
          data_d   = shadow_q;
          shadow_d = count_step(op_q, shadow_q);
        end
        default: begin
          load_d   = 1'b1;
          updown_d = 1'b0;
          data_d   = shadow_q;
          shadow_d = shadow_q;
        end
      endcase
    end else begin
      state_d  = ST_IDLE;
      remain_d = 4'd0;
      load_d   = 1'b1;
      updown_d = 1'b0;
      data_d   = shadow_q;
      shadow_d = shadow_q;
    end
  end

  // Error pulse for an accepted reserved op.
  always_comb begin
    if (accept_s && (cmd_op == OP_RSVD)) begin
      err_d = 1'b1;
    end else begin
      err_d = 1'b0;
    end
  end

  // FIFO storage write; cleared on reset so a flushed queue holds no stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        fifo_mem_q[i] <= 10'd0;
      end
    end else if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= {cmd_op, cmd_data, cmd_len};
    end
  end

  // FIFO control registers plus ready/busy flags derived from next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      cnt_q    <= 3'd0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ready_q  <= (cnt_d != 3'd4);
      busy_q   <= (state_d == ST_RUN) || (cnt_d != 3'd0);
      err_q    <= err_d;
    end
  end

  // Sequencer state, shadow counter and counter-facing outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_UP;
      remain_q <= 4'd0;
      shadow_q <= 4'd0;
      load_q   <= 1'b1;
      updown_q <= 1'b0;
      data_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      remain_q <= remain_d;
      shadow_q <= shadow_d;
      load_q   <= load_d;
      updown_q <= updown_d;
      data_q   <= data_d;
    end
  end

  assign cmd_ready = ready_q;
  assign load      = load_q;
  assign updown    = updown_q;
  assign data      = data_q;
  assign busy      = busy_q;
  assign fifo_cnt  = cnt_q;
  assign cmd_err   = err_q;

  counter_cmd_seq_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .cmd_ready (ready_q),
    .fifo_cnt  (cnt_q),
    .busy      (busy_q),
    .run       (state_q == ST_RUN)
  );

endmodule

// File: doc/counter_cmd_seq.md
COUNTER_CMD_SEQ -- requirements
Module: counter_cmd_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, ports named as follows.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  asynchronous active-low reset; low clears all state immediately.
REQ-004 cmd_valid  input  1  command offered this cycle.
REQ-005 cmd_op  input  2  00 UP, 01 DOWN, 10 LOAD, 11 reserved.
REQ-006 cmd_data  input  4  load value; used by LOAD only.
REQ-007 cmd_len  input  4  UP/DOWN run length; N means N+1 count cycles (1..16).
REQ-008 cmd_ready  output  1  command accepted at posedge when cmd_valid && cmd_ready.
REQ-009 load  output  1  registered; drives the up/down counter load input.
REQ-010 updown  output  1  registered; drives counter direction (1 = up).
REQ-011 data  output  4  registered; drives counter load data.
REQ-012 busy  output  1  high while executing a command or while the FIFO is non-empty.
REQ-013 fifo_cnt  output  3  registered FIFO occupancy, 0..4.
REQ-014 cmd_err  output  1  one-cycle pulse on acceptance of a reserved op.

Function
REQ-015 Commands SHALL pass through a 4-entry FIFO; cmd_ready = (fifo_cnt < 4), derived from registered state only; no push-through.
REQ-016 Reserved op SHALL be accepted (handshake completes) but not stored; cmd_err SHALL be high the cycle after acceptance.
REQ-017 A 4-bit shadow register SHALL track the downstream counter value, updated with the same arithmetic the counter applies.
REQ-018 FSM states SHALL be IDLE, RUN; LOAD executes as a single RUN cycle.
REQ-019 IDLE: load=1, data=shadow, updown=0, freezing the counter at its current value.
REQ-020 Pop SHALL occur at a posedge when the FIFO is non-empty and the FSM is in IDLE or in the final cycle of the current command; popped command drives outputs from that edge.
REQ-021 LOAD: one cycle load=1, data=cmd_data; shadow <= cmd_data.
REQ-022 UP: N+1 cycles load=0, updown=1; shadow increments mod 16 each cycle (F wraps to 0).
REQ-023 DOWN: N+1 cycles load=0, updown=0; shadow decrements mod 16 each cycle (0 wraps to F).
REQ-024 Back-to-back commands SHALL issue with zero idle cycles between them.
REQ-025 After the final cycle with the FIFO empty, the FSM SHALL return to IDLE and hold shadow.
REQ-026 Simultaneous push and pop SHALL leave fifo_cnt unchanged; push when fifo_cnt=4 SHALL NOT occur (cmd_ready low).
REQ-027 Latency: a command accepted into an empty FIFO while IDLE SHALL drive outputs from the second posedge after acceptance.
REQ-028 busy SHALL be (state != IDLE) || (fifo_cnt != 0).

Reset
REQ-029 While rst=0: load=1, data=0, updown=0, cmd_err=0, fifo_cnt=0, busy=0, cmd_ready=0, shadow=0, FSM=IDLE.
REQ-030 Reset asserted mid-command SHALL abort the command and flush the FIFO; no pending command executes after release.
REQ-031 First posedge after release SHALL show cmd_ready=1 with IDLE hold of count 0.

Verification
REQ-032 Reset release, no commands -> load=1, data=0 continuously; counter stays 0.
REQ-033 LOAD 0x9 then UP len=2 -> one cycle load=1/data=9, then 3 up cycles; counter sequence 9,A,B,C, then held at C.
REQ-034 LOAD 0xE, UP len=3 -> counter E,F,0,1,2; shadow matches; IDLE data=2.
REQ-035 LOAD 0x1, DOWN len=2 -> counter 1,0,F,E; hold at E.
REQ-036 Push 5 commands (UP len=15 first) back-to-back -> cmd_ready low after 4 stored entries, fifo_cnt peaks at 4, no gaps between commands.
REQ-037 Reserved op with cmd_valid -> accepted, cmd_err pulses 1 cycle, fifo_cnt unchanged; rst low during UP len=15 -> outputs per REQ-029 immediately, FIFO empty.
